serial_subtractor: RTL

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, with a single registered borrow. It is the subtracting counterpart of the team's combinational adder cells and the first sequential arithmetic block in the adder library. It trades latency for area in datapaths where a parallel subtractor is unnecessary.

---
 rtl/serial_sub_pkg.sv | 10 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
//   ss_state_e : FSM state encoding (SS_IDLE, SS_RUN)
package serial_sub_pkg;

  typedef enum logic {
    SS_IDLE = 1'b0,
    SS_RUN  = 1'b1
  } ss_state_e;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// 1-bit combinational full-subtractor cell computing A - B - Bin.
// Ports:
//   A, B, Bin : minuend bit, subtrahend bit, borrow in
//   DIFF      : difference bit
//   BORROW    : borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic DIFF,
  output logic BORROW
);

  assign DIFF   = A ^ B ^ Bin;
  assign BORROW = (~A & B) | (~(A ^ B) & Bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = (a - b) mod 2^WIDTH,
// one bit per clock, LSB first, single registered borrow.
// Optional feature macro: SERIAL_SUB_OVF_EN (registered signed overflow on ovf).
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   start           : request, sampled only when idle
//   a, b            : operands, captured on the accepted start edge
//   busy            : operation in progress
//   done            : one-cycle completion pulse
//   diff/borrow_out : result and final borrow, held until next completion
//   ovf             : signed overflow (0 when SERIAL_SUB_OVF_EN is undefined)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ss_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic fs_d, fs_b;
  logic last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Single shared cell: operand LSBs and the running borrow
  full_subtractor u_fs (
    .A      (a_sh_q[0]),
    .B      (b_sh_q[0]),
    .Bin    (borrow_q),
    .DIFF   (fs_d),
    .BORROW (fs_b)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SS_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SS_IDLE: if (start)    state_d = SS_RUN;
      SS_RUN:  if (last_bit) state_d = SS_IDLE;
    endcase
  end

  // Datapath and output-register next values
  always_comb begin
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    busy_d       = (state_d == SS_RUN);
    case (state_q)
      SS_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SS_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        borrow_d = fs_b;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Counter parks at 0 so it never wraps for non-power-of-2 WIDTH
          cnt_d        = '0;
          diff_d       = {fs_d, res_q[WIDTH-1:1]};
          borrow_out_d = fs_b;
          done_d       = 1'b1;
        end
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of the operand registers, so keep copies
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  // Overflow: operand signs differ and the result sign differs from a's;
  // on the last bit fs_d is the result MSB
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if ((state_q == SS_IDLE) && start) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if ((state_q == SS_RUN) && last_bit) begin
      ovf_d = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule : serial_subtractor
